// File: rtl/disaster_alarm_monitor.sv
// Hazard alarm monitor: hysteretic thresholds, persistence FSMs, live or latched alarms,
// severity count, blinking siren and a saturating event counter.

module disaster_alarm_fsm #(
    parameter int PERSIST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_on,
    input  logic i_off,
    input  logic i_mode,
    input  logic i_ack,
    output logic o_led,
    output logic o_led_nxt,
    output logic o_enter,
    output logic o_safe
);
    localparam int CNT_W = $clog2(PERSIST + 1);

    localparam logic [1:0] S_SAFE   = 2'd0;
    localparam logic [1:0] S_ARMING = 2'd1;
    localparam logic [1:0] S_ALERT  = 2'd2;
    localparam logic [1:0] S_HELD   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_SAFE: begin
                if (i_on) begin
                    if (PERSIST == 1) begin
                        w_state_nxt = S_ALERT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_ARMING;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            S_ARMING: begin
                if (!i_on) begin
                    w_state_nxt = S_SAFE;
                    w_cnt_nxt   = '0;
                end else if ((r_cnt + CNT_W'(1)) == CNT_W'(PERSIST)) begin
                    w_state_nxt = S_ALERT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ALERT: begin
                if (i_off) w_state_nxt = i_mode ? S_HELD : S_SAFE;
            end
            S_HELD: begin
                // Acknowledge wins even while the hazard is still present.
                if (i_ack) w_state_nxt = S_SAFE;
            end
            default: begin
                w_state_nxt = S_SAFE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_SAFE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_led     = (r_state == S_ALERT) || (r_state == S_HELD);
    assign o_led_nxt = (w_state_nxt == S_ALERT) || (w_state_nxt == S_HELD);
    assign o_enter   = (w_state_nxt == S_ALERT) && (r_state != S_ALERT);
    assign o_safe    = (r_state == S_SAFE);
endmodule

module disaster_alarm_monitor #(
    parameter int W             = 7,
    parameter int SW            = 5,
    parameter int FLOOD_ON      = 30,
    parameter int CYCLONE_ON    = 50,
    parameter int QUAKE_ON      = 5,
    parameter int TSU_SEA_ON    = 50,
    parameter int TSU_QUAKE_SEA = 20,
    parameter int HYST          = 5,
    parameter int HYST_S        = 1,
    parameter int PERSIST       = 4,
    parameter int BLINK_DIV     = 8,
    parameter int CW            = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  rain,
    input  logic [SW-1:0] seismic,
    input  logic [W-1:0]  wind,
    input  logic [W-1:0]  sea,
    input  logic          mode,
    input  logic          ack,
    output logic          flood_led,
    output logic          cyclone_led,
    output logic          earthquake_led,
    output logic          tsunami_led,
    output logic          safe_led,
    output logic          danger_led,
    output logic [2:0]    alarm_level,
    output logic          siren,
    output logic [CW-1:0] event_count
);
    localparam int NUM_HAZ = 4;
    localparam int DIV_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SUM_W   = CW + 3;

    localparam logic [W-1:0]  L_FLOOD_ON   = W'(FLOOD_ON);
    localparam logic [W-1:0]  L_FLOOD_OFF  = W'(FLOOD_ON - HYST);
    localparam logic [W-1:0]  L_CYC_ON     = W'(CYCLONE_ON);
    localparam logic [W-1:0]  L_CYC_OFF    = W'(CYCLONE_ON - HYST);
    localparam logic [SW-1:0] L_QUAKE_ON   = SW'(QUAKE_ON);
    localparam logic [SW-1:0] L_QUAKE_OFF  = SW'(QUAKE_ON - HYST_S);
    localparam logic [W-1:0]  L_TSU_ON     = W'(TSU_SEA_ON);
    localparam logic [W-1:0]  L_TSU_OFF    = W'(TSU_SEA_ON - HYST);
    localparam logic [W-1:0]  L_TSU_QSEA   = W'(TSU_QUAKE_SEA);

    logic [NUM_HAZ-1:0] w_on;
    logic [NUM_HAZ-1:0] w_off;
    logic [NUM_HAZ-1:0] w_led;
    logic [NUM_HAZ-1:0] w_led_nxt;
    logic [NUM_HAZ-1:0] w_enter;
    logic [NUM_HAZ-1:0] w_safe;
    logic               w_tsu_quake;
    logic               w_danger_nxt;
    logic [2:0]         w_enter_cnt;
    logic [SUM_W-1:0]   w_ev_sum;

    logic [DIV_W-1:0]   r_div;
    logic               r_siren;
    logic [CW-1:0]      r_event;

    // Hazard index: 0 flood, 1 cyclone, 2 earthquake, 3 tsunami.
    assign w_tsu_quake = w_led[2] && (sea >= L_TSU_QSEA);

    assign w_on[0]  = rain >= L_FLOOD_ON;
    assign w_off[0] = rain <  L_FLOOD_OFF;
    assign w_on[1]  = wind >= L_CYC_ON;
    assign w_off[1] = wind <  L_CYC_OFF;
    assign w_on[2]  = seismic >= L_QUAKE_ON;
    assign w_off[2] = seismic <  L_QUAKE_OFF;
    assign w_on[3]  = (sea >= L_TSU_ON) || w_tsu_quake;
    assign w_off[3] = (sea <  L_TSU_OFF) && !w_tsu_quake;

    for (genvar g = 0; g < NUM_HAZ; g++) begin : g_haz
        disaster_alarm_fsm #(.PERSIST(PERSIST)) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_on      (w_on[g]),
            .i_off     (w_off[g]),
            .i_mode    (mode),
            .i_ack     (ack),
            .o_led     (w_led[g]),
            .o_led_nxt (w_led_nxt[g]),
            .o_enter   (w_enter[g]),
            .o_safe    (w_safe[g])
        );
    end

    assign w_danger_nxt = |w_led_nxt;
    assign w_enter_cnt  = {2'b00, w_enter[0]} + {2'b00, w_enter[1]}
                        + {2'b00, w_enter[2]} + {2'b00, w_enter[3]};
    assign w_ev_sum     = SUM_W'(r_event) + SUM_W'(w_enter_cnt);

    // Divider holds at 0 on the rising edge so the first toggle lands BLINK_DIV edges later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_siren <= 1'b0;
        end else if (!w_danger_nxt) begin
            r_div   <= '0;
            r_siren <= 1'b0;
        end else if (danger_led) begin
            if (r_div == DIV_W'(BLINK_DIV - 1)) begin
                r_div   <= '0;
                r_siren <= ~r_siren;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end else begin
            r_div <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_event <= '0;
        end else if (w_ev_sum > SUM_W'({CW{1'b1}})) begin
            r_event <= '1;
        end else begin
            r_event <= w_ev_sum[CW-1:0];
        end
    end

    assign flood_led      = w_led[0];
    assign cyclone_led    = w_led[1];
    assign earthquake_led = w_led[2];
    assign tsunami_led    = w_led[3];
    assign danger_led     = |w_led;
    assign safe_led       = &w_safe;
    assign alarm_level    = {2'b00, w_led[0]} + {2'b00, w_led[1]}
                          + {2'b00, w_led[2]} + {2'b00, w_led[3]};
    assign siren          = r_siren;
    assign event_count    = r_event;
endmodule

// File: tb/tb_disaster_alarm_monitor.sv
// Directed-vector bench for disaster_alarm_monitor with hand-computed expectations.

module tb_disaster_alarm_monitor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] rain, wind, sea;
    logic [4:0] seismic;
    logic       mode, ack;
    logic       flood_led, cyclone_led, earthquake_led, tsunami_led;
    logic       safe_led, danger_led, siren;
    logic [2:0] alarm_level;
    logic [7:0] event_count;

    int n_vec = 0;
    int n_bad = 0;
    int exp_ev;

    disaster_alarm_monitor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rain           (rain),
        .seismic        (seismic),
        .wind           (wind),
        .sea            (sea),
        .mode           (mode),
        .ack            (ack),
        .flood_led      (flood_led),
        .cyclone_led    (cyclone_led),
        .earthquake_led (earthquake_led),
        .tsunami_led    (tsunami_led),
        .safe_led       (safe_led),
        .danger_led     (danger_led),
        .alarm_level    (alarm_level),
        .siren          (siren),
        .event_count    (event_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int r, input int s, input int w, input int q);
        rain    = 7'(r);
        seismic = 5'(s);
        wind    = 7'(w);
        sea     = 7'(q);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; ack = 1'b1;
        set_in(127, 31, 127, 127);
        step(2);
        chk("rst_flood", flood_led, 0);
        chk("rst_tsu", tsunami_led, 0);
        chk("rst_safe", safe_led, 1);
        chk("rst_level", alarm_level, 0);
        chk("rst_event", event_count, 0);
        chk("rst_siren", siren, 0);
        ack = 1'b0;
        set_in(0, 0, 0, 0);
        rst_n = 1'b1;
        step(1);

        // persistence latency
        set_in(35, 0, 0, 0);
        step(3);
        chk("p_flood3", flood_led, 0);
        chk("p_safe_arming", safe_led, 0);
        step(1);
        chk("p_flood4", flood_led, 1);
        chk("p_event", event_count, 1);
        chk("p_danger", danger_led, 1);
        chk("p_level", alarm_level, 1);
        set_in(0, 0, 0, 0);
        step(1);
        chk("p_clear", flood_led, 0);
        set_in(35, 0, 0, 0);
        step(3);
        set_in(1, 0, 0, 0);
        step(1);
        chk("abort_flood", flood_led, 0);
        chk("abort_safe", safe_led, 1);
        step(3);
        chk("abort_flood2", flood_led, 0);
        chk("abort_event", event_count, 1);

        // live hysteresis
        set_in(35, 0, 0, 0);
        step(4);
        chk("h_flood_on", flood_led, 1);
        chk("h_event", event_count, 2);
        set_in(27, 0, 0, 0);
        step(2);
        chk("h_band_hold", flood_led, 1);
        set_in(24, 0, 0, 0);
        step(1);
        chk("h_off", flood_led, 0);
        set_in(0, 0, 0, 0);
        step(1);

        // latched mode
        mode = 1'b1;
        set_in(0, 0, 55, 0);
        step(3);
        chk("l_cyc3", cyclone_led, 0);
        step(1);
        chk("l_cyc4", cyclone_led, 1);
        chk("l_event", event_count, 3);
        set_in(0, 0, 5, 0);
        step(3);
        chk("l_held", cyclone_led, 1);
        chk("l_held_safe", safe_led, 0);
        mode = 1'b0;
        step(1);
        chk("l_mode_chg", cyclone_led, 1);
        mode = 1'b1; ack = 1'b1;
        step(1);
        chk("l_ack", cyclone_led, 0);
        chk("l_ack_safe", safe_led, 1);
        ack = 1'b0;
        set_in(0, 0, 55, 0);
        step(4);
        chk("l_rearm", cyclone_led, 1);
        chk("l_event2", event_count, 4);
        ack = 1'b1;
        step(1);
        chk("l_ack_alert", cyclone_led, 1);
        ack = 1'b0;
        set_in(0, 0, 5, 0);
        step(1);
        set_in(0, 0, 55, 0);
        ack = 1'b1;
        step(1);
        chk("l_ack_on", cyclone_led, 0);
        ack = 1'b0;
        step(3);
        chk("l_rearm3", cyclone_led, 0);
        step(1);
        chk("l_rearm4", cyclone_led, 1);
        chk("l_event3", event_count, 5);
        set_in(0, 0, 0, 0);
        step(1);
        ack = 1'b1;
        step(1);
        ack = 1'b0; mode = 1'b0;
        chk("l_release", cyclone_led, 0);

        // quake-assisted tsunami
        set_in(0, 6, 0, 25);
        step(3);
        chk("q_eq3", earthquake_led, 0);
        step(1);
        chk("q_eq4", earthquake_led, 1);
        chk("q_tsu_not_yet", tsunami_led, 0);
        chk("q_event", event_count, 6);
        step(3);
        chk("q_tsu3", tsunami_led, 0);
        step(1);
        chk("q_tsu4", tsunami_led, 1);
        chk("q_level", alarm_level, 2);
        chk("q_event2", event_count, 7);
        set_in(0, 0, 0, 0);
        step(1);
        chk("q_clear_lvl", alarm_level, 0);

        // everything at max, siren cadence, reset mid-alert
        set_in(127, 31, 127, 127);
        step(4);
        chk("m_level", alarm_level, 4);
        chk("m_event", event_count, 11);
        chk("m_siren0", siren, 0);
        step(7);
        chk("m_siren7", siren, 0);
        step(1);
        chk("m_siren8", siren, 1);
        step(8);
        chk("m_siren16", siren, 0);
        step(8);
        chk("m_siren24", siren, 1);
        rst_n = 1'b0;
        step(1);
        chk("m_rst_level", alarm_level, 0);
        chk("m_rst_event", event_count, 0);
        chk("m_rst_siren", siren, 0);
        chk("m_rst_safe", safe_led, 1);
        rst_n = 1'b1;
        set_in(0, 0, 0, 0);
        step(1);

        // siren clears on the falling edge of danger
        set_in(127, 31, 127, 127);
        step(12);
        chk("f_siren_on", siren, 1);
        set_in(0, 0, 0, 0);
        step(1);
        chk("f_danger", danger_led, 0);
        chk("f_siren_off", siren, 0);
        exp_ev = 4;
        chk("f_event", event_count, exp_ev);

        // event counter saturation
        for (int i = 0; i < 64; i++) begin
            set_in(127, 31, 127, 127);
            step(4);
            exp_ev = (exp_ev + 4 > 255) ? 255 : exp_ev + 4;
            chk("sat_event", event_count, exp_ev);
            set_in(0, 0, 0, 0);
            step(1);
        end
        chk("sat_final", event_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
